// File: rtl/mul_hilo_sequencer_if.sv
// Multiply/mfhi-mflo bus between decode/execute control and the HI/LO sequencer.
// Latency and backpressure are owned by the sequencer; stall is the only throttle.
interface mul_hilo_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             mf_req;
  logic             mf_hi;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output start, signed_op, op_a, op_b, flush, mf_req, mf_hi,
    input  busy, stall, done, hi, lo, mf_data
  );

  modport slave (
    input  start, signed_op, op_a, op_b, flush, mf_req, mf_hi,
    output busy, stall, done, hi, lo, mf_data
  );
endinterface

// File: rtl/mul_hilo_sequencer.sv
// Radix-2 shift-add multiplier owning HI/LO; WIDTH+1 busy cycles, result and done after edge WIDTH+1.
// No queueing: start while busy is dropped, stall holds decode; flush aborts without touching HI/LO.
module mul_hilo_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_hilo_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  // Negating the most-negative value wraps back to itself, which is the correct unsigned magnitude.
  always_comb begin
    accept  = (state == IDLE) && bus.start && !bus.flush;
    a_mag   = (bus.signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    b_mag   = (bus.signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    product = neg ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX) && !bus.flush;
      if (accept) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC && !bus.flush) begin
        // Carry out of the upper-half add shifts into the top bit.
        acc    <= {sum, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
      if (state == FIX && !bus.flush) begin
        hi_q <= product[2*WIDTH-1:WIDTH];
        lo_q <= product[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    bus.busy    = (state != IDLE);
    bus.stall   = bus.busy | (bus.mf_req & bus.busy);
    bus.done    = done_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
    bus.mf_data = bus.mf_hi ? hi_q : lo_q;
  end

endmodule

// File: doc/mul_hilo_sequencer.md
Name: mul_hilo_sequencer

Overview:
- Multi-cycle radix-2 shift-add multiplier controller that owns the HI/LO result registers.
- Sequences every mul/muli issued by the control decode (ALUOp = mul) and serves mfhi/mflo reads.
- Raises pipeline stall interlocks while a product is in flight.
- Sits beside the ALU in the execute stage; the register file writes back from mf_data.

Parameters:
- WIDTH, 16, operand width; HI and LO are each WIDTH bits, full product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a multiply; decode asserts it for ALUOp = mul with RegWrite
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- op_a  in  WIDTH  multiplicand, sampled with start
- op_b  in  WIDTH  multiplier, sampled with start
- flush  in  1  abort the in-flight multiply (branch/jump squash)
- mf_req  in  1  mfhi/mflo in decode
- mf_hi  in  1  1 selects HI, 0 selects LO (driven from MfhiLo_)
- busy  out  1  multiply in progress
- stall  out  1  freeze fetch/decode
- done  out  1  one-cycle pulse: HI/LO just updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mf_data  out  WIDTH  combinational: mf_hi ? hi : lo

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; hi = lo = 0; busy = done = stall = 0; counter = 0; internal accumulators = 0.
  - Reset mid-operation discards the product entirely.
- FSM states: IDLE, CALC, FIX.
  - busy = (state != IDLE).
- IDLE:
  - On start & !flush: latch |op_a| and |op_b| (magnitude only when signed_op = 1, raw otherwise).
  - Latch neg = signed_op & (a_msb ^ b_msb).
  - Clear the 2*WIDTH accumulator, counter = 0, go to CALC.
- CALC, one iteration per cycle:
  - If multiplier LSB = 1, add multiplicand to the accumulator upper half (carry kept).
  - Shift accumulator/multiplier right by 1; counter++.
  - After WIDTH iterations (counter = WIDTH-1 on the edge), go to FIX.
- FIX:
  - Product = neg ? two's-complement negate of the 2*WIDTH accumulator : accumulator.
  - hi <= product[2W-1:W], lo <= product[W-1:0]; done <= 1 for exactly the next cycle; state <= IDLE.
- Latency:
  - Start sampled at edge E0; CALC occupies edges E1..E_WIDTH; HI/LO and done become visible after edge E_(WIDTH+1).
  - busy is high for WIDTH+1 cycles.
- Back-to-back:
  - start in the cycle where done = 1 is accepted (state is IDLE).
  - hi/lo hold the previous product until the new FIX edge.
- start while busy: ignored and never queued; decode must hold the instruction via stall.
- stall = busy | (mf_req & busy). mf_req while busy stalls until the cycle done is high; mf_data is then valid.
- flush:
  - Synchronous; in any state returns to IDLE next edge.
  - hi/lo unchanged, no done pulse.
  - flush and start in the same cycle: flush wins, start dropped.
- Edge operands:
  - Signed most-negative operand (0x8000 for WIDTH = 16): magnitude is taken as the WIDTH-bit unsigned value 0x8000, so the result is exact.
  - Zero operand gives zero with neg forced irrelevant (negating 0 yields 0).
- hi/lo change only on a FIX edge or reset.

Test Plan:
- WIDTH=16, unsigned 3 × 5: start one cycle → busy 17 cycles, then done = 1 with hi = 0x0000, lo = 0x000F; stall high throughout busy.
- Signed −3 (0xFFFD) × 5 → hi = 0xFFFF, lo = 0xFFF1; signed 0x8000 × 0x8000 → hi = 0x4000, lo = 0x0000.
- Unsigned 0xFFFF × 0xFFFF → hi = 0xFFFE, lo = 0x0001. A second start in the done cycle with 2 × 2 → previous values held 17 cycles, then lo = 0x0004, hi = 0.
- mf_req = 1, mf_hi = 1 held from cycle 3 of a multiply → stall stays 1 until done. In the done cycle mf_data = new hi; with mf_hi = 0, mf_data = lo combinationally.
- flush at cycle 8 of 7 × 9 (prior hi/lo = 0/0x000F) → busy drops next cycle, no done, hi/lo stay 0/0x000F. flush + start together in IDLE → busy stays 0.
- rst_n low asynchronously at cycle 10 of a multiply → busy, done, stall, hi, lo all 0 immediately without a clock edge. After release, a fresh 3 × 5 gives lo = 0x000F.
